traffic_fsm: RTL and testbench



---
 rtl/traffic_fsm_pkg.sv | 31 +++
 rtl/traffic_fsm_tick_gen.sv | 27 ++
 rtl/traffic_fsm.sv | 107 ++++++++++
 tb/tb_traffic_fsm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_fsm_pkg.sv
// Shared light codes, state encodings and the state-to-lights decode for the intersection
// sequencer.
package traffic_fsm_pkg;

  typedef enum logic [1:0] {
    LightRed    = 2'd0,
    LightYellow = 2'd1,
    LightGreen  = 2'd2
  } light_e;

  typedef enum logic [2:0] {
    StMg  = 3'd0,
    StMy  = 3'd1,
    StAr1 = 3'd2,
    StSg  = 3'd3,
    StSy  = 3'd4,
    StAr2 = 3'd5
  } state_e;

  // Returns {main, side}; unknown encodings show all-red so a code of 3 is never produced.
  function automatic logic [3:0] state_lights(state_e st);
    case (st)
      StMg:    state_lights = {LightGreen, LightRed};
      StMy:    state_lights = {LightYellow, LightRed};
      StSg:    state_lights = {LightRed, LightGreen};
      StSy:    state_lights = {LightRed, LightYellow};
      default: state_lights = {LightRed, LightRed};
    endcase
  endfunction

endpackage

// File: rtl/traffic_fsm_tick_gen.sv
// Free-running divider producing a one-clock tick every CLK_DIV clocks.
module traffic_fsm_tick_gen #(
  parameter int unsigned CLK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q;

  assign tick = (div_q == DivMax);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

endmodule

// File: rtl/traffic_fsm.sv
// Main/side road light sequencer: demand-driven side phase with a one-shot extension and
// all-red clearance between opposing greens.
module traffic_fsm
  import traffic_fsm_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 25_000_000,
  parameter int unsigned T_BASE   = 6,
  parameter int unsigned T_EXT    = 3,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_ALLRED = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor,
  output logic [1:0] main_out,
  output logic [1:0] side_out,
  output logic [2:0] state_out,
  output logic [3:0] time_left
);

  localparam logic [3:0] TBase   = 4'(T_BASE);
  localparam logic [3:0] TExt    = 4'(T_EXT);
  localparam logic [3:0] TYel    = 4'(T_YEL);
  localparam logic [3:0] TAllred = 4'(T_ALLRED);

  logic       tick;
  state_e     state_q;
  logic [3:0] cnt_q;
  logic       ext_used_q;

  traffic_fsm_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StMg;
      cnt_q      <= TBase;
      ext_used_q <= 1'b0;
    end else begin
      case (state_q)
        StMg, StMy, StAr1, StSg, StSy, StAr2: begin
          if (tick) begin
            if (cnt_q != 4'd1) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              // Interval expired: the state lasted exactly its loaded number of ticks.
              case (state_q)
                StMg: begin
                  // Without demand cnt stays at 1 so every later tick re-tests the sensor.
                  if (sensor) begin
                    state_q <= StMy;
                    cnt_q   <= TYel;
                  end
                end
                StMy: begin
                  state_q <= StAr1;
                  cnt_q   <= TAllred;
                end
                StAr1: begin
                  state_q    <= StSg;
                  cnt_q      <= TBase;
                  ext_used_q <= 1'b0;
                end
                StSg: begin
                  if (sensor && !ext_used_q) begin
                    cnt_q      <= TExt;
                    ext_used_q <= 1'b1;
                  end else begin
                    state_q <= StSy;
                    cnt_q   <= TYel;
                  end
                end
                StSy: begin
                  state_q <= StAr2;
                  cnt_q   <= TAllred;
                end
                StAr2: begin
                  state_q <= StMg;
                  cnt_q   <= TBase;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          state_q    <= StMg;
          cnt_q      <= TBase;
          ext_used_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    {main_out, side_out} = state_lights(state_q);
  end

  assign state_out = state_q;
  assign time_left = cnt_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Scoreboard bench for traffic_fsm: a phase-table model predicts every cycle's outputs.
module tb_traffic_fsm;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned T_BASE   = 6;
  localparam int unsigned T_EXT    = 3;
  localparam int unsigned T_YEL    = 2;
  localparam int unsigned T_ALLRED = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sensor;
  logic [1:0] main_out;
  logic [1:0] side_out;
  logic [2:0] state_out;
  logic [3:0] time_left;

  traffic_fsm #(
    .CLK_DIV (CLK_DIV),
    .T_BASE  (T_BASE),
    .T_EXT   (T_EXT),
    .T_YEL   (T_YEL),
    .T_ALLRED(T_ALLRED)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sensor   (sensor),
    .main_out (main_out),
    .side_out (side_out),
    .state_out(state_out),
    .time_left(time_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int rem;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Phase tables: duration in ticks and the light shown on each road.
  int dur_tab[6]  = '{int'(T_BASE), int'(T_YEL), int'(T_ALLRED),
                      int'(T_BASE), int'(T_YEL), int'(T_ALLRED)};
  int main_tab[6] = '{2, 1, 0, 0, 0, 0};
  int side_tab[6] = '{0, 0, 0, 2, 1, 0};

  int m_p;
  int m_rem;
  int m_cyc;
  bit m_ext;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_p   = 0;
    m_rem = int'(T_BASE);
    m_cyc = 0;
    m_ext = 1'b0;
  endtask

  // Advance the model by one clock edge with sensor level s.
  task automatic model_step(input bit s);
    m_cyc++;
    if (m_cyc % int'(CLK_DIV) == 0) begin
      if (m_rem > 1) begin
        m_rem--;
      end else if (m_p == 0 && !s) begin
        m_rem = 1;
      end else if (m_p == 3 && s && !m_ext) begin
        m_rem = int'(T_EXT);
        m_ext = 1'b1;
      end else begin
        m_p   = (m_p + 1) % 6;
        m_rem = dur_tab[m_p];
        if (m_p == 3) m_ext = 1'b0;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_main"}, int'(main_out), 2);
    check({tag, "_side"}, int'(side_out), 0);
    check({tag, "_state"}, int'(state_out), 0);
    check({tag, "_time"}, int'(time_left), int'(T_BASE));
  endtask

  // Asynchronous assert away from any edge, hold, then synchronous release at a negedge.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1 check_reset_vals({tag, "_assert"});
    @(negedge clk);
    @(negedge clk);
    check_reset_vals({tag, "_hold"});
    reset_n = 1'b1;
    model_reset();
  endtask

  // Modes: 0 off, 1 on, 2 on except during side green, 3 pulses only between ticks plus
  // a demand exactly at tick 9, other: random level.
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      bit s;
      int nxt;
      nxt = m_cyc + 1;
      case (mode)
        0: s = 1'b0;
        1: s = 1'b1;
        2: s = (m_p != 3);
        3: begin
          if (nxt % int'(CLK_DIV) == 0) s = (nxt / int'(CLK_DIV) == 9);
          else s = 1'($urandom_range(0, 1));
        end
        default: s = 1'($urandom_range(0, 1));
      endcase
      sensor = s;
      model_step(s);
      exp_q.push_back('{m_p, m_rem, m_cyc});
      @(negedge clk);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("state_out@%0d", e.cyc), int'(state_out), e.p);
      check($sformatf("time_left@%0d", e.cyc), int'(time_left), e.rem);
      check($sformatf("main_out@%0d", e.cyc), int'(main_out), main_tab[e.p]);
      check($sformatf("side_out@%0d", e.cyc), int'(side_out), side_tab[e.p]);
    end
    n_checks++;
    if ((main_out == 2'd2 && side_out != 2'd0) || (side_out == 2'd2 && main_out != 2'd0) ||
        main_out == 2'd3 || side_out == 2'd3) begin
      n_fail++;
      $display("FAIL safety: main_out=%0d side_out=%0d", main_out, side_out);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    reset_n = 1'b1;
    sensor  = 1'b0;
    @(negedge clk);
    do_reset("por");

    run(80, 0);   // idle main road for 20 ticks
    run(100, 1);  // constant demand: full cycle with one extension
    run(120, 2);  // demand withdrawn on side-green entry: no extension
    do_reset("rst2");
    run(60, 3);   // late demand at tick 9, glitches between ticks ignored
    run(400, 4);  // random sensor level

    // Drive into the middle of side green, then reset asynchronously.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_p == 3 && m_rem == 4) found = 1'b1;
      else run(1, 1);
    end
    check("reach_side_green", int'(found), 1);
    do_reset("mid_sg");
    run(80, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
